mem_bus_responder: RTL

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_array.sv | 47 ++++
 rtl/mem_bus_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM encoding and parity helper for the 16x8 memory bus responder.
// Optional feature macro MEM_BUS_PARITY_EN (see mem_bus_array / mem_bus_responder).
package mem_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_bus_array.sv
// 16x8 storage: synchronous write, combinational read, optional clear on RESET; no backpressure.
// With MEM_BUS_PARITY_EN defined, a per-word even-parity bit is stored (PAR_INJ flips it) and checked on read.
module mem_bus_array
  import mem_bus_pkg::*;
#(
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef MEM_BUS_PARITY_EN
  input  logic              wr_par_inj,
  output logic              rd_par_err,
`endif
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RESET && INIT_ZERO) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

`ifdef MEM_BUS_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RESET && INIT_ZERO) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
    end else if (wr_en) begin
      par_mem[wr_addr] <= even_par(wr_data) ^ wr_par_inj;
    end
  end

  assign rd_par_err = even_par(mem[rd_addr]) != par_mem[rd_addr];
`endif

endmodule

// File: rtl/mem_bus_responder.sv
// Memory bus responder: ACK one cycle after the DONE state, WAIT_STATES+2 cycles after accept; no queuing, requests ignored while BUSY.
// MEM_BUS_PARITY_EN adds the PAR_INJ port and parity error reporting on reads.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
`ifdef MEM_BUS_PARITY_EN
  input  logic              PAR_INJ,
`endif
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              ACK,
  output logic              BUSY,
  output logic              ERR
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t            state;
  logic [2:0]        wait_cnt;
  logic [3:0]        cnt_nxt;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_rd;
  logic              cap_wr;
  logic              accept;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_par_err;

  assign accept  = (state == IDLE) && REQ && (READ || WRITE);
  assign cnt_nxt = {1'b0, wait_cnt} + 4'd1;

`ifdef MEM_BUS_PARITY_EN
  logic cap_inj;
  logic wr_inj;
`endif

  // The write lands on the edge entering DONE; with no wait states that is the accept edge itself.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cap_addr;
    wr_data = cap_data;
`ifdef MEM_BUS_PARITY_EN
    wr_inj  = cap_inj;
`endif
    if (!RESET) begin
      if (accept && WRITE && !READ && WS == 4'd0) begin
        wr_en   = 1'b1;
        wr_addr = ADDR;
        wr_data = DATA_IN;
`ifdef MEM_BUS_PARITY_EN
        wr_inj  = PAR_INJ;
`endif
      end else if (state == WAIT && cap_wr && !cap_rd && cnt_nxt == WS) begin
        wr_en = 1'b1;
      end
    end
  end

  mem_bus_array #(
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (cap_addr),
`ifdef MEM_BUS_PARITY_EN
    .wr_par_inj (wr_inj),
    .rd_par_err (rd_par_err),
`endif
    .rd_data    (rd_data)
  );

`ifndef MEM_BUS_PARITY_EN
  assign rd_par_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_rd   <= 1'b0;
      cap_wr   <= 1'b0;
`ifdef MEM_BUS_PARITY_EN
      cap_inj  <= 1'b0;
`endif
      DATA_OUT <= '0;
      ACK      <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_addr <= ADDR;
            cap_data <= DATA_IN;
            cap_rd   <= READ;
            cap_wr   <= WRITE;
`ifdef MEM_BUS_PARITY_EN
            cap_inj  <= PAR_INJ;
`endif
            wait_cnt <= '0;
            BUSY     <= 1'b1;
            state    <= (WS == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= cnt_nxt[2:0];
          if (cnt_nxt == WS) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          ACK   <= 1'b1;
          ERR   <= (cap_rd && cap_wr) || (cap_rd && !cap_wr && rd_par_err);
          if (cap_rd && !cap_wr) DATA_OUT <= rd_data;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
